seg7_bus_display: RTL

Memory-mapped 4-digit seven-segment display controller on the processor's shared 8-bit bus. It is the output-side counterpart of the switch input peripheral: the CPU writes hex digits and a control byte, and the block time-multiplexes the four digits onto the common-anode display. Registers can optionally be read back over the same tristate bus.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_decoder.sv | 30 +++
 rtl/seg7_bus_display.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment bus display: register offsets and reset/blank values.
// Pure definitions; no latency or flow control involved.
package seg7_pkg;

    typedef enum logic [1:0] {
        REG_DIG_LO = 2'd0,
        REG_DIG_HI = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_t;

    localparam logic [7:0] CTRL_RESET = 8'h0F;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, bits [6:0] = g..a.
// Purely combinational, zero latency, no flow control.
module seg7_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg7_bus_display.sv
// Bus-mapped 4-digit seven-segment scanner; readback over the tristate bus when SEG7_READBACK_EN is defined.
// Outputs lag index/register changes by 1 clk, readback data by 1 clk; bus accesses are never stalled.
module seg7_bus_display
    import seg7_pkg::*;
#(
    parameter logic [7:0] SevenSegBaseAddr = 8'hD0,
    parameter int         RefreshWidth     = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT
);

    logic [7:0]              offset;
    logic                    in_range;
    reg_off_t                reg_sel;
    logic [7:0]              dig_lo;
    logic [7:0]              dig_hi;
    logic [7:0]              ctrl;
    logic [RefreshWidth-1:0] presc;
    logic [1:0]              idx;
    logic [3:0]              nibble;
    logic [3:0]              enables;
    logic [3:0]              dots;
    logic [6:0]              seg_dec;

    // Subtracting the base keeps the window check to a single zero test on the upper bits.
    assign offset   = BUS_ADDR - SevenSegBaseAddr;
    assign in_range = (offset[7:2] == 6'd0);
    assign reg_sel  = reg_off_t'(offset[1:0]);
    assign enables  = ctrl[3:0];
    assign dots     = ctrl[7:4];

    always_comb begin
        nibble = dig_lo[3:0];
        case (idx)
            2'd0:    nibble = dig_lo[3:0];
            2'd1:    nibble = dig_lo[7:4];
            2'd2:    nibble = dig_hi[3:0];
            default: nibble = dig_hi[7:4];
        endcase
    end

    seg7_decoder u_decoder (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc      <= '0;
            idx        <= 2'd0;
            dig_lo     <= 8'h00;
            dig_hi     <= 8'h00;
            ctrl       <= CTRL_RESET;
            SEG_SELECT <= 4'hF;
            HEX_OUT    <= 8'hFF;
        end else begin
            presc <= presc + 1'b1;
            if (&presc) begin
                idx <= idx + 2'd1;
            end
            if (in_range && BUS_WE) begin
                case (reg_sel)
                    REG_DIG_LO: dig_lo <= BUS_DATA;
                    REG_DIG_HI: dig_hi <= BUS_DATA;
                    REG_CTRL:   ctrl   <= BUS_DATA;
                    default:    ;
                endcase
            end
            SEG_SELECT <= enables[idx] ? ~(4'b0001 << idx) : 4'hF;
            HEX_OUT    <= {~(dots[idx] & enables[idx]), enables[idx] ? seg_dec : SEG_BLANK};
        end
    end

`ifdef SEG7_READBACK_EN
    logic [7:0] rd_mux;
    logic [7:0] rd_dat;
    logic       rd_en;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_DIG_LO: rd_mux = dig_lo;
            REG_DIG_HI: rd_mux = dig_hi;
            REG_CTRL:   rd_mux = ctrl;
            default:    rd_mux = 8'h00;
        endcase
    end

    // Drive-enable lasts exactly one cycle per sampled read, so writes and idle cycles release the bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_en  <= 1'b0;
            rd_dat <= 8'h00;
        end else begin
            rd_en  <= in_range && !BUS_WE;
            rd_dat <= rd_mux;
        end
    end

    assign BUS_DATA = rd_en ? rd_dat : 8'hzz;
`else
    assign BUS_DATA = 8'hzz;
`endif

endmodule
